// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: run controller around a programmable serial pattern
// detector. A run scans a window of qualified serial bits and counts
// overlapping occurrences of the loaded pattern, with a saturating counter
// and a sticky overflow flag.
//
// Handshake: start is accepted only in IDLE (the same cycle may also load a
// new config with cfg_we, which the run then uses). busy is high from the
// cycle after an accepted start until the cycle after done. done is a
// one-cycle pulse marking a completed run. An aborted run returns to IDLE
// without a done pulse.
module seq_detect_ctrl #(
    parameter int PAT_W = 4,
    parameter int WIN_W = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,        // asynchronous, active-low
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [WIN_W-1:0] cfg_window,
    input  logic             start,
    input  logic             abort,
    input  logic             x,
    input  logic             x_valid,
    output logic             busy,
    output logic             done,
    output logic             y,
    output logic [CNT_W-1:0] match_count,
    output logic             overflow,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Bit count at which the shift register first holds a full pattern.
    localparam logic [WIN_W:0] PAT_LEN = (WIN_W + 1)'(PAT_W);

    state_t           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic [PAT_W-1:0] sr_q, sr_d;
    logic [WIN_W-1:0] bitcnt_q, bitcnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             y_q, y_d;

    logic [PAT_W-1:0] sr_next;
    logic [WIN_W:0]   bits_seen;
    logic [WIN_W-1:0] eff_win;
    logic             hit;

    // Shift register contents and bit count after sampling the current bit.
    assign sr_next   = {sr_q[PAT_W-2:0], x};
    assign bits_seen = {1'b0, bitcnt_q} + (WIN_W + 1)'(1);
    assign hit       = (bits_seen >= PAT_LEN) && (sr_next == pat_q);
    // A start in the same cycle as cfg_we runs with the freshly loaded window.
    assign eff_win   = cfg_we ? cfg_window : win_q;

    // State and datapath registers; reset clears everything including config.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            pat_q    <= '0;
            win_q    <= '0;
            sr_q     <= '0;
            bitcnt_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            y_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            pat_q    <= pat_d;
            win_q    <= win_d;
            sr_q     <= sr_d;
            bitcnt_q <= bitcnt_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            y_q      <= y_d;
        end
    end

    // Next-state and datapath update for IDLE / SCAN / DONE.
    always_comb begin
        state_d  = state_q;
        pat_d    = pat_q;
        win_d    = win_q;
        sr_d     = sr_q;
        bitcnt_d = bitcnt_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        y_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cfg_we) begin
                    pat_d = cfg_pattern;
                    win_d = cfg_window;
                end
                if (start) begin
                    sr_d     = '0;
                    bitcnt_d = '0;
                    cnt_d    = '0;
                    ovf_d    = 1'b0;
                    state_d  = (eff_win == '0) ? S_DONE : S_SCAN;
                end
            end
            S_SCAN: begin
                // abort wins over a bit sampled in the same cycle
                if (abort) begin
                    state_d = S_IDLE;
                end else if (x_valid) begin
                    sr_d     = sr_next;
                    bitcnt_d = bits_seen[WIN_W-1:0];
                    if (hit) begin
                        y_d = 1'b1;
                        if (&cnt_q) begin
                            ovf_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    if (bits_seen == {1'b0, win_q}) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy        = (state_q == S_SCAN) || (state_q == S_DONE);
    assign done        = (state_q == S_DONE);
    assign y           = y_q;
    assign match_count = cnt_q;
    assign overflow    = ovf_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Bench for seq_detect_ctrl: directed scenarios followed by random runs,
// checked against a bit-list reference model. A second instance with a
// 2-bit counter shares all inputs so saturation can be reached.
module tb_seq_detect_ctrl;

    localparam int PAT_W = 4;
    localparam int WIN_W = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic             cfg_we;
    logic [PAT_W-1:0] cfg_pattern;
    logic [WIN_W-1:0] cfg_window;
    logic             start;
    logic             abort;
    logic             x;
    logic             x_valid;

    logic       busy, done, y, overflow;
    logic [7:0] match_count;
    logic [1:0] dbg_state;
    logic       busy_s, done_s, y_s, overflow_s;
    logic [1:0] match_count_s;
    logic [1:0] dbg_state_s;

    seq_detect_ctrl #(.PAT_W(PAT_W), .WIN_W(WIN_W), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_window(cfg_window), .start(start), .abort(abort), .x(x),
        .x_valid(x_valid), .busy(busy), .done(done), .y(y),
        .match_count(match_count), .overflow(overflow), .dbg_state(dbg_state)
    );

    seq_detect_ctrl #(.PAT_W(PAT_W), .WIN_W(WIN_W), .CNT_W(2)) dut_s (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_window(cfg_window), .start(start), .abort(abort), .x(x),
        .x_valid(x_valid), .busy(busy_s), .done(done_s), .y(y_s),
        .match_count(match_count_s), .overflow(overflow_s), .dbg_state(dbg_state_s)
    );

    // ---------------- scoreboard counters ----------------
    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // A run is a list of accepted bits; a match is "the last PAT_W bits of
    // the list spell the pattern". Counts saturate at 2^CNT_W-1.
    bit         m_run;      // scanning after this edge
    bit         m_fin;      // completion cycle after this edge
    bit         m_y;
    bit [3:0]   m_pat;
    int         m_win;
    bit         bits[$];
    int         m_cnt8, m_cnt2;
    bit         m_ovf8, m_ovf2;

    task automatic model_reset();
        m_run = 0; m_fin = 0; m_y = 0; m_pat = '0; m_win = 0;
        bits.delete();
        m_cnt8 = 0; m_cnt2 = 0; m_ovf8 = 0; m_ovf2 = 0;
    endtask

    function automatic bit tail_matches();
        int v = 0;
        int n = bits.size();
        if (n < PAT_W) return 0;
        for (int i = 0; i < PAT_W; i++) v = (v << 1) | int'(bits[n - PAT_W + i]);
        return v == int'(m_pat);
    endfunction

    // Advance the model across one rising edge using the applied inputs.
    task automatic model_edge();
        m_y = 0;
        if (m_fin) begin
            m_fin = 0;
        end else if (m_run) begin
            if (abort) begin
                m_run = 0;
            end else if (x_valid) begin
                bits.push_back(x);
                if (tail_matches()) begin
                    m_y = 1;
                    if (m_cnt8 == 255) m_ovf8 = 1; else m_cnt8++;
                    if (m_cnt2 == 3)   m_ovf2 = 1; else m_cnt2++;
                end
                if (bits.size() == m_win) begin
                    m_run = 0;
                    m_fin = 1;
                end
            end
        end else begin
            if (cfg_we) begin
                m_pat = cfg_pattern;
                m_win = int'(cfg_window);
            end
            if (start) begin
                bits.delete();
                m_cnt8 = 0; m_cnt2 = 0; m_ovf8 = 0; m_ovf2 = 0;
                if (m_win == 0) m_fin = 1; else m_run = 1;
            end
        end
    endtask

    task automatic check_all();
        chk("busy",     busy,          m_run || m_fin);
        chk("done",     done,          m_fin);
        chk("y",        y,             m_y);
        chk("count",    match_count,   m_cnt8);
        chk("ovf",      overflow,      m_ovf8);
        chk("busy_s",   busy_s,        m_run || m_fin);
        chk("done_s",   done_s,        m_fin);
        chk("y_s",      y_s,           m_y);
        chk("count_s",  match_count_s, m_cnt2);
        chk("ovf_s",    overflow_s,    m_ovf2);
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input logic xv, input logic xb, input logic st, input logic ab,
                        input logic we, input logic [3:0] pat, input logic [7:0] win);
        @(negedge clk);
        x_valid = xv; x = xb; start = st; abort = ab;
        cfg_we = we; cfg_pattern = pat; cfg_window = win;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic bit_in(input logic xb);
        step(1'b1, xb, 1'b0, 1'b0, 1'b0, 4'h0, 8'h0);
    endtask

    task automatic idle_cyc();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h0);
    endtask

    logic [7:0] basic_bits;

    // ---------------- directed + random stimulus ----------------
    initial begin
        basic_bits = 8'b1011_0111;  // sent MSB first: 1,0,1,1,0,1,1,1
        reset = 1'b0; cfg_we = 0; cfg_pattern = '0; cfg_window = '0;
        start = 0; abort = 0; x = 0; x_valid = 0;
        model_reset();
        #12;
        check_all();                            // reset state
        @(negedge clk); reset = 1'b1;

        // basic run
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b1011, 8'd8);
        for (int i = 7; i >= 0; i--) begin
            bit_in(basic_bits[i]);
            if (i == 4 || i == 1) chk("basic_y", y, 1);
        end
        chk("basic_done", done, 1);
        chk("basic_cnt", match_count, 2);
        idle_cyc();
        chk("basic_idle", busy, 0);

        // gapped input, reusing the loaded config
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 8'h0);
        for (int i = 7; i >= 0; i--) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h0);
            bit_in(basic_bits[i]);
        end
        chk("gap_cnt", match_count, 2);
        idle_cyc();

        // saturation on the 2-bit counter instance; start in DONE is ignored
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000, 8'd10);
        for (int i = 0; i < 10; i++) bit_in(1'b0);
        chk("sat_cnt_s", match_count_s, 3);
        chk("sat_ovf_s", overflow_s, 1);
        chk("sat_cnt", match_count, 7);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 8'h0);
        idle_cyc();

        // window zero
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b1011, 8'd0);
        chk("win0_done", done, 1);
        idle_cyc();

        // abort, with start/cfg_we during SCAN ignored
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b1011, 8'd8);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0000, 8'd2);
        bit_in(1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'b1111, 8'd0);
        bit_in(1'b1);
        bit_in(1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 8'h0);
        chk("abort_cnt", match_count, 1);
        chk("abort_busy", busy, 0);
        idle_cyc();

        // reset mid-run
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 8'h0);
        for (int i = 7; i >= 4; i--) bit_in(basic_bits[i]);
        @(negedge clk); reset = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk); reset = 1'b1;
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b1011, 8'd8);
        for (int i = 7; i >= 0; i--) bit_in(basic_bits[i]);
        chk("rerun_cnt", match_count, 2);
        idle_cyc();

        // random runs
        for (int r = 0; r < 40; r++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, ($urandom_range(0, 3) != 0),
                 4'($urandom_range(0, 15)), 8'($urandom_range(0, 40)));
            for (int k = 0; k < 600 && (m_run || m_fin); k++) begin
                step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 7) == 0), ($urandom_range(0, 59) == 0),
                     ($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)),
                     8'($urandom_range(0, 40)));
            end
            chk("run_ended", busy, 0);
            if ($urandom_range(0, 1) == 1) idle_cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
